// File: rtl/uart_pkg.sv
// Shared UART definitions: IRQ arbiter state encoding and CSR reset defaults.
package uart_pkg;

    // States of the interrupt arbiter: waiting, signalling a source, rate-limiting.
    typedef enum logic [1:0] {
        IRQ_ARB_IDLE,
        IRQ_ARB_ACTIVE,
        IRQ_ARB_HOLDOFF
    } irq_arb_state_t;

    // Reset value of the hold-off CSR: no hold-off, interrupts may re-fire after one idle cycle.
    localparam logic [15:0] UART_IRQ_HOLDOFF_DEFAULT = 16'd0;

endpackage

// File: rtl/uart_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational and reusable by other UART status logic.
module uart_prio_enc #(
    parameter int EVENTS_NUM = 32,
    parameter int ID_W       = $clog2(EVENTS_NUM)
) (
    input  logic [EVENTS_NUM-1:0] i_req,
    output logic [ID_W-1:0]       o_idx,
    output logic                  o_any
);

    // Scan from the top down so the lowest set bit is the last one to overwrite the index.
    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        for (int i = EVENTS_NUM - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_irq_arbiter.sv
// Collapses the UART IRQ bus into one registered CPU interrupt with a source ID,
// an acknowledge handshake and a programmable hold-off that bounds the interrupt rate.
module uart_irq_arbiter
    import uart_pkg::*;
#(
    parameter int EVENTS_NUM = 32,
    parameter int HOLDOFF_W  = 16,
    parameter int ID_W       = $clog2(EVENTS_NUM)
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [EVENTS_NUM-1:0] i_irq_bus,
    input  logic [HOLDOFF_W-1:0]  i_holdoff_cycles,
    input  logic                  i_irq_ack,
    output logic                  o_irq,
    output logic [ID_W-1:0]       o_irq_id,
    output logic                  o_holdoff_busy
);

    irq_arb_state_t        state_q, state_d;
    logic [HOLDOFF_W-1:0]  cnt_q, cnt_d;
    logic                  irq_q, irq_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic                  busy_q, busy_d;

    logic [ID_W-1:0]       enc_idx;
    logic                  enc_any;

    uart_prio_enc #(
        .EVENTS_NUM (EVENTS_NUM),
        .ID_W       (ID_W)
    ) u_prio_enc (
        .i_req (i_irq_bus),
        .o_idx (enc_idx),
        .o_any (enc_any)
    );

    // State, counter and output registers; reset drops everything with no pending memory.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q <= IRQ_ARB_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: ack beats withdrawal, the ID only changes when a new interrupt starts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        id_d    = id_q;
        busy_d  = busy_q;
        unique case (state_q)
            IRQ_ARB_IDLE: begin
                if (enc_any) begin
                    id_d    = enc_idx;
                    irq_d   = 1'b1;
                    state_d = IRQ_ARB_ACTIVE;
                end
            end
            IRQ_ARB_ACTIVE: begin
                if (i_irq_ack) begin
                    irq_d = 1'b0;
                    if (i_holdoff_cycles == '0) begin
                        state_d = IRQ_ARB_IDLE;
                    end else begin
                        cnt_d   = i_holdoff_cycles;
                        busy_d  = 1'b1;
                        state_d = IRQ_ARB_HOLDOFF;
                    end
                end else if (!i_irq_bus[id_q]) begin
                    irq_d   = 1'b0;
                    state_d = IRQ_ARB_IDLE;
                end
            end
            IRQ_ARB_HOLDOFF: begin
                if (cnt_q == HOLDOFF_W'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IRQ_ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - HOLDOFF_W'(1);
                end
            end
            default: begin
                state_d = IRQ_ARB_IDLE;
                irq_d   = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_irq          = irq_q;
    assign o_irq_id       = id_q;
    assign o_holdoff_busy = busy_q;

endmodule

// File: tb/tb_uart_irq_arbiter.sv
// Self-checking bench for uart_irq_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_uart_irq_arbiter;

    logic        clock;
    logic        nrst;
    logic [31:0] irqBus;
    logic [15:0] holdoffCycles;
    logic        irqAck;
    logic        irq;
    logic [4:0]  irqId;
    logic        holdoffBusy;

    int testsRun = 0;
    int testsFailed = 0;

    // Behavioural model: is an interrupt being signalled, which source, cycles of hold-off left.
    bit mIrq = 1'b0;
    int mId = 0;
    int mHoldLeft = 0;

    typedef struct {
        logic        nrst;
        logic [31:0] bus;
        logic [15:0] hold;
        logic        ack;
        logic        expIrq;
        logic [4:0]  expId;
        logic        expBusy;
    } vector_t;

    vector_t vecs[26];

    uart_irq_arbiter dut (
        .i_clk            (clock),
        .i_nrst           (nrst),
        .i_irq_bus        (irqBus),
        .i_holdoff_cycles (holdoffCycles),
        .i_irq_ack        (irqAck),
        .o_irq            (irq),
        .o_irq_id         (irqId),
        .o_holdoff_busy   (holdoffBusy)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Lowest set bit: isolate it with v & -v, then take its log2.
    function automatic int lowestIndex(logic [31:0] v);
        logic [31:0] iso;
        iso = v & (~v + 32'd1);
        return $clog2(iso);
    endfunction

    // One clock edge of the model, using the inputs that are stable at that edge.
    task automatic modelStep();
        if (!nrst) begin
            mIrq = 1'b0;
            mId = 0;
            mHoldLeft = 0;
        end else if (mHoldLeft > 0) begin
            mHoldLeft = mHoldLeft - 1;
        end else if (mIrq) begin
            if (irqAck) begin
                mIrq = 1'b0;
                mHoldLeft = int'(holdoffCycles);
            end else if (!irqBus[mId]) begin
                mIrq = 1'b0;
            end
        end else if (irqBus != 32'd0) begin
            mIrq = 1'b1;
            mId = lowestIndex(irqBus);
        end
    endtask

    // Advance one cycle; outputs are sampled afterwards on the falling edge.
    task automatic tick();
        @(posedge clock);
        modelStep();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic n, input logic [31:0] bus,
                                 input logic [15:0] hold, input logic ack);
        nrst = n;
        irqBus = bus;
        holdoffCycles = hold;
        irqAck = ack;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic eIrq,
                               input logic [4:0] eId, input logic eBusy);
        testsRun++;
        if (irq !== eIrq || irqId !== eId || holdoffBusy !== eBusy) begin
            testsFailed++;
            $display("[TB] FAIL %s: got irq=%0b id=%0d busy=%0b, expected irq=%0b id=%0d busy=%0b",
                     name, irq, irqId, holdoffBusy, eIrq, eId, eBusy);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mIrq, 5'(mId), mHoldLeft > 0);
    endtask

    initial begin
        int busyCount;
        logic [31:0] rBus;
        logic [15:0] rHold;

        nrst = 1'b0;
        irqBus = 32'hFFFF_FFFF;
        holdoffCycles = 16'd0;
        irqAck = 1'b0;

        // Reset with all requests high, then release.
        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 16'd0,   1'b0, 1'b0, 5'd0, 1'b0};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 16'd0,   1'b0, 1'b0, 5'd0, 1'b0};
        vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 16'd0,   1'b0, 1'b0, 5'd0, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 16'd0,   1'b0, 1'b1, 5'd0, 1'b0};
        // Priority, frozen ID, ack with zero hold-off.
        vecs[4]  = '{1'b1, 32'h0000_0048, 16'd0,   1'b1, 1'b0, 5'd0, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0048, 16'd0,   1'b0, 1'b1, 5'd3, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0049, 16'd0,   1'b0, 1'b1, 5'd3, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0049, 16'd0,   1'b1, 1'b0, 5'd3, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0049, 16'd0,   1'b0, 1'b1, 5'd0, 1'b0};
        // Hold-off of 5 with bit 7 high; reprogramming and ack mid-hold-off have no effect.
        vecs[9]  = '{1'b1, 32'h0000_0080, 16'd5,   1'b1, 1'b0, 5'd0, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_0080, 16'd100, 1'b0, 1'b0, 5'd0, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0080, 16'd100, 1'b0, 1'b0, 5'd0, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0080, 16'd100, 1'b1, 1'b0, 5'd0, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_0080, 16'd100, 1'b0, 1'b0, 5'd0, 1'b1};
        vecs[14] = '{1'b1, 32'h0000_0080, 16'd100, 1'b0, 1'b0, 5'd0, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_0080, 16'd100, 1'b0, 1'b1, 5'd7, 1'b0};
        // Withdrawal: no hold-off, quick re-assertion.
        vecs[16] = '{1'b1, 32'h0000_0004, 16'd10,  1'b0, 1'b0, 5'd7, 1'b0};
        vecs[17] = '{1'b1, 32'h0000_0004, 16'd10,  1'b0, 1'b1, 5'd2, 1'b0};
        vecs[18] = '{1'b1, 32'h0000_0000, 16'd10,  1'b0, 1'b0, 5'd2, 1'b0};
        vecs[19] = '{1'b1, 32'h0000_0010, 16'd10,  1'b0, 1'b1, 5'd4, 1'b0};
        // Ack together with withdrawal takes the hold-off path; ack in IDLE is ignored.
        vecs[20] = '{1'b1, 32'h0000_0000, 16'd3,   1'b1, 1'b0, 5'd4, 1'b1};
        vecs[21] = '{1'b1, 32'h0000_0000, 16'd3,   1'b0, 1'b0, 5'd4, 1'b1};
        vecs[22] = '{1'b1, 32'h0000_0000, 16'd3,   1'b0, 1'b0, 5'd4, 1'b1};
        vecs[23] = '{1'b1, 32'h0000_0000, 16'd3,   1'b0, 1'b0, 5'd4, 1'b0};
        vecs[24] = '{1'b1, 32'h0000_0000, 16'd3,   1'b1, 1'b0, 5'd4, 1'b0};
        vecs[25] = '{1'b1, 32'h0000_0000, 16'd3,   1'b0, 1'b0, 5'd4, 1'b0};

        @(negedge clock);
        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].nrst, vecs[i].bus, vecs[i].hold, vecs[i].ack);
            checkOutput($sformatf("vec%0d", i), vecs[i].expIrq, vecs[i].expId, vecs[i].expBusy);
        end

        // Reset while the hold-off counter sits at 40.
        applyStimulus(1'b1, 32'h0000_0200, 16'd50, 1'b0);
        checkOutput("rst_hold_start", 1'b1, 5'd9, 1'b0);
        applyStimulus(1'b1, 32'h0000_0200, 16'd50, 1'b1);
        checkOutput("rst_hold_ack", 1'b0, 5'd9, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h0000_0200, 16'd50, 1'b0);
        checkOutput("rst_hold_mid", 1'b0, 5'd9, 1'b1);
        applyStimulus(1'b0, 32'h0000_0200, 16'd50, 1'b0);
        checkOutput("rst_hold_abort", 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0000, 16'd50, 1'b0);
        checkOutput("rst_hold_idle", 1'b0, 5'd0, 1'b0);

        // Maximum hold-off: busy for exactly 65535 cycles, no wrap.
        applyStimulus(1'b1, 32'h8000_0000, 16'hFFFF, 1'b0);
        checkOutput("max_start", 1'b1, 5'd31, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 16'hFFFF, 1'b1);
        checkOutput("max_ack", 1'b0, 5'd31, 1'b1);
        irqAck = 1'b0;
        busyCount = 1;
        while (holdoffBusy === 1'b1 && busyCount < 70000) begin
            tick();
            if (holdoffBusy === 1'b1) busyCount++;
        end
        testsRun++;
        if (busyCount != 65535) begin
            testsFailed++;
            $display("[TB] FAIL max_holdoff_len: got %0d busy cycles, expected 65535", busyCount);
        end
        checkOutput("max_end", 1'b0, 5'd31, 1'b0);
        tick();
        checkOutput("max_refire", 1'b1, 5'd31, 1'b0);

        // Randomized traffic against the behavioural model.
        rBus = 32'h0000_0001;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rBus = ($urandom_range(0, 3) == 0) ? 32'd0 :
                       ((32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31)));
            end
            rHold = 16'($urandom_range(0, 6));
            applyStimulus(($urandom_range(0, 39) != 0), rBus, rHold, ($urandom_range(0, 3) == 0));
            checkModel($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
